ecc_encode_pipe: RTL and testbench



---
 rtl/ecc_pkg.sv | 20 ++
 rtl/ecc_hamming_parity.sv | 40 ++++
 rtl/ecc_encode_pipe.sv | 90 +++++++++
 tb/tb_ecc_encode_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: Hamming width calculation and power-of-two test.
package ecc_pkg;

  // Smallest p with 2^p >= dw + p + 1.
  function automatic int get_parity_width(input int dw);
    int p;
    p = 0;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  function automatic int get_cw_width(input int dw);
    return dw + get_parity_width(dw);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ecc_hamming_parity.sv
// Combinational Hamming encoder: scatters data over non-power-of-two positions
// and fills each power-of-two position with its coverage parity.
module ecc_hamming_parity
  import ecc_pkg::*;
#(
  parameter  int DataWidth   = 64,
  localparam int ParityWidth = get_parity_width(DataWidth),
  localparam int CwWidth     = get_cw_width(DataWidth)
) (
  input  logic [DataWidth-1:0] data_i,
  output logic [CwWidth-1:0]   cw_o
);

  logic [CwWidth-1:0]                  placed;
  logic [ParityWidth-1:0][CwWidth-1:0] terms;
  logic [ParityWidth-1:0]              par;

  // Position p (1-based) carries data bit p-1-clog2(p) when p is not a power of two.
  for (genvar p = 1; p <= CwWidth; p++) begin : g_pos
    if (is_pow2(p)) begin : g_par
      assign placed[p-1] = 1'b0;
      assign cw_o[p-1]   = par[$clog2(p)];
    end else begin : g_dat
      assign placed[p-1] = data_i[p-1-$clog2(p)];
      assign cw_o[p-1]   = placed[p-1];
    end
  end

  for (genvar k = 0; k < ParityWidth; k++) begin : g_chk
    for (genvar p = 1; p <= CwWidth; p++) begin : g_term
      if (((p >> k) & 1) != 0) begin : g_in
        assign terms[k][p-1] = placed[p-1];
      end else begin : g_out
        assign terms[k][p-1] = 1'b0;
      end
    end
    assign par[k] = ^terms[k];
  end

endmodule

// File: rtl/ecc_encode_pipe.sv
// Two-stage streaming SECDED encoder with valid/ready on both sides.
// Optional error injection at the stage-B load: define ECC_ENCODE_ERR_INJ_EN.
module ecc_encode_pipe
  import ecc_pkg::*;
#(
  parameter  int DataWidth   = 64,
  localparam int ParityWidth = get_parity_width(DataWidth),
  localparam int CwWidth     = DataWidth + ParityWidth,
  localparam int EncWidth    = CwWidth + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [EncWidth-1:0] data_o
`ifdef ECC_ENCODE_ERR_INJ_EN
  ,
  input  logic                inj_req_i,
  input  logic [EncWidth-1:0] inj_mask_i,
  output logic                inj_pending_o
`endif
);

  typedef struct packed {
    logic               parity;
    logic [CwWidth-1:0] code_word;
  } enc_t;

  logic [CwWidth-1:0]  cw_next, cw_a;
  logic                valid_a, ready_b, load_b;
  enc_t                enc_b;
  logic [EncWidth-1:0] out_mask;

  ecc_hamming_parity #(.DataWidth(DataWidth)) u_parity (
    .data_i (data_i),
    .cw_o   (cw_next)
  );

  assign ready_b = !valid_o || ready_i;
  assign ready_o = !valid_a || ready_b;
  assign load_b  = valid_a && ready_b;
  assign enc_b   = '{parity: ^cw_a, code_word: cw_a};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_a <= 1'b0;
      cw_a    <= '0;
    end else if (ready_o) begin
      valid_a <= valid_i;
      if (valid_i) cw_a <= cw_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (ready_b) begin
      valid_o <= valid_a;
      if (valid_a) data_o <= enc_b ^ out_mask;
    end
  end

`ifdef ECC_ENCODE_ERR_INJ_EN
  logic [EncWidth-1:0] inj_mask_q;

  // A request in the same cycle as a load wins over the armed mask.
  assign out_mask = inj_req_i     ? inj_mask_i :
                    inj_pending_o ? inj_mask_q : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inj_mask_q    <= '0;
      inj_pending_o <= 1'b0;
    end else if (load_b) begin
      inj_mask_q    <= '0;
      inj_pending_o <= 1'b0;
    end else if (inj_req_i) begin
      inj_mask_q    <= inj_mask_i;
      inj_pending_o <= 1'b1;
    end
  end
`else
  assign out_mask = '0;
`endif

endmodule

// File: tb/tb_ecc_encode_pipe.sv
// Scoreboard bench for ecc_encode_pipe (DataWidth=8) against a positional Hamming model.
module tb_ecc_encode_pipe;

  logic        clk = 1'b0;
  logic        rst, valid_i, ready_o, valid_o, ready_i;
  logic [7:0]  data_i;
  logic [12:0] data_o;
`ifdef ECC_ENCODE_ERR_INJ_EN
  logic        inj_req_i, inj_pending_o;
  logic [12:0] inj_mask_i;
`endif

  always #5 clk = ~clk;

  ecc_encode_pipe #(.DataWidth(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
`ifdef ECC_ENCODE_ERR_INJ_EN
    ,
    .inj_req_i     (inj_req_i),
    .inj_mask_i    (inj_mask_i),
    .inj_pending_o (inj_pending_o)
`endif
  );

  typedef struct {
    logic [12:0] v;
    int          stamp;
    int          stalls;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, failures = 0, cyc = 0, stalls = 0;
  bit          rand_ready = 0, holding = 0;
  logic [12:0] held, inj_next = '0;

  // Reference: walk positions 1..12, place data in non-power-of-two slots,
  // then count covered ones for each check position.
  function automatic logic [12:0] ref_enc(input logic [7:0] d);
    logic [7:0]  sh;
    logic [11:0] cw;
    sh = d;
    cw = '0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (sh[0]) cw = cw | (12'd1 << (pos - 1));
        sh = sh >> 1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      int cnt;
      cnt = 0;
      for (int pos = 1; pos <= 12; pos++)
        if ((pos & (1 << k)) != 0 && ((cw >> (pos - 1)) & 12'd1) != 0) cnt++;
      if (cnt % 2 == 1) cw = cw | (12'd1 << ((1 << k) - 1));
    end
    return {($countones(cw) % 2) == 1, cw};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Hold valid until accepted; returns at 1ns after the accepting edge.
  task automatic send(input logic [7:0] d, output int waits);
    bit acc;
    valid_i = 1'b1;
    data_i  = d;
    waits   = 0;
    for (int t = 0; t < 500; t++) begin
      @(posedge clk);
      acc = ready_o;
      #1;
      if (acc) begin
        valid_i = 1'b0;
        data_i  = 8'($urandom);
        return;
      end
      waits++;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout: actual=not accepted required=accepted data=%0h", d);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0 && !valid_o) break;
      @(posedge clk);
      #1;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: push expected on input handshake, pop and compare on output handshake.
  always @(posedge clk) begin
    if (!rst) begin
      cyc++;
      if (valid_i && ready_o) begin
        exp_q.push_back('{v: ref_enc(data_i) ^ inj_next, stamp: cyc, stalls: stalls});
        inj_next = '0;
      end
      if (holding) begin
        checks++;
        if (!valid_o || data_o !== held) begin
          failures++;
          $display("FAIL hold_stable: actual=%0b/%0h required=1/%0h", valid_o, data_o, held);
        end
      end
      holding = valid_o && !ready_i;
      held    = data_o;
      if (holding) stalls++;
      if (valid_o && ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: actual=%0h required=no word", data_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (data_o !== e.v) begin
            failures++;
            $display("FAIL data_o: actual=%0h required=%0h", data_o, e.v);
          end
          if (e.stalls == stalls) begin
            checks++;
            if (cyc - e.stamp != 2) begin
              failures++;
              $display("FAIL latency: actual=%0d required=2", cyc - e.stamp);
            end
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
`ifdef ECC_ENCODE_ERR_INJ_EN
    inj_req_i = 1'b0; inj_mask_i = '0;
`endif
    #2 rst = 1'b1;
    #1;
    chk("reset_valid_o", valid_o, 0);
    chk("reset_data_o", data_o, 0);
    chk("reset_ready_o", ready_o, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_reset_ready_o", ready_o, 1);

    // Single words: exact encoding visible one edge after stage A loads.
    send(8'h01, w);
    @(posedge clk); #1;
    chk("enc_01_valid", valid_o, 1);
    chk("enc_01", data_o, 13'h1007);
    send(8'hFF, w);
    @(posedge clk); #1;
    chk("enc_ff", data_o, 13'h0F77);
    send(8'h00, w);
    @(posedge clk); #1;
    chk("enc_00", data_o, 13'h0000);
    drain();

    // Back-to-back at full rate.
    send(8'h00, w); chk("b2b_ready0", w, 0);
    send(8'h01, w); chk("b2b_ready1", w, 0);
    send(8'hFF, w); chk("b2b_ready2", w, 0);
    drain();

    // Backpressure: two words fill the pipe, the third is refused.
    ready_i = 1'b0;
    send(8'hA5, w);
    send(8'h3C, w);
    valid_i = 1'b1; data_i = 8'h5A;
    repeat (3) begin @(posedge clk); #1; end
    chk("stall_ready_o", ready_o, 0);
    chk("stall_valid_o", valid_o, 1);
    data_i = 8'($urandom); valid_i = 1'b0;
    @(posedge clk); #1;
    ready_i = 1'b1;
    send(8'h5A, w);
    drain();

    // Async reset with both stages full drops everything.
    ready_i = 1'b0;
    send(8'h11, w);
    send(8'h22, w);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid_o", valid_o, 0);
    chk("mid_rst_data_o", data_o, 0);
    exp_q.delete();
    holding = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_ready_o", ready_o, 1);
    repeat (4) begin @(posedge clk); #1; end
    chk("no_stale_valid_o", valid_o, 0);

`ifdef ECC_ENCODE_ERR_INJ_EN
    inj_req_i = 1'b1; inj_mask_i = 13'h0004;
    @(posedge clk); #1;
    inj_req_i = 1'b0;
    chk("inj_pending_set", inj_pending_o, 1);
    inj_next = 13'h0004;
    send(8'h01, w);
    @(posedge clk); #1;
    chk("inj_single_err", data_o, 13'h1003);
    chk("inj_pending_clr", inj_pending_o, 0);
    send(8'h01, w);
    @(posedge clk); #1;
    chk("inj_next_clean", data_o, 13'h1007);
    drain();
    inj_req_i = 1'b1; inj_mask_i = 13'h1000;
    @(posedge clk); #1;
    inj_req_i = 1'b0;
    inj_next = 13'h1000;
    send(8'h01, w);
    @(posedge clk); #1;
    chk("inj_parity_only", data_o, 13'h0007);
    drain();
    inj_next = 13'h0001;
    send(8'hFF, w);
    inj_req_i = 1'b1; inj_mask_i = 13'h0001;
    @(posedge clk); #1;
    inj_req_i = 1'b0;
    chk("inj_coincide_data", data_o, 13'h0F76);
    chk("inj_coincide_pending", inj_pending_o, 0);
    drain();
`endif

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(8'($urandom), w);
    end
    @(posedge clk); #2;
    rand_ready = 1'b0;
    ready_i = 1'b1;
    #1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
